sim_clock_gen: RTL

Parametrised, runtime-programmable multi-channel clock/tick generator for the simulator front end. Each of CH_NUM channels divides clk by a loadable divisor and produces a square clock and a single-cycle tick strobe. At reset, channel 0 defaults to the bearing rate (273 Hz from 33 MHz) and channel 1 to the range rate (200 kHz). Channels can be individually enabled, phase-aligned by a common sync pulse, and reprogrammed glitch-free.

---
 rtl/sim_clock_gen.sv | 111 +++++++++++
 1 files changed

// File: rtl/sim_clock_gen.sv
// sim_clock_gen: multi-channel programmable clock/tick divider with shadowed, glitch-free reprogramming.
// Define SIM_CLOCK_GEN_IMMEDIATE_EN to apply config writes at once, restarting the channel's period.
module sim_clock_gen #(
   parameter int                CH_NUM   = 2,
   parameter int                DIV_W    = 17,
   parameter logic [DIV_W-1:0]  DEF_DIV0 = DIV_W'(120878),
   parameter logic [DIV_W-1:0]  DEF_DIV1 = DIV_W'(164),
   parameter logic              DEF_MODE = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [CH_NUM-1:0] en,
   input  logic              sync,
   input  logic              cfg_wr,
   input  logic [1:0]        cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic              cfg_mode,
   output logic [CH_NUM-1:0] clk_out,
   output logic [CH_NUM-1:0] tick,
   output logic              cfg_err
);
   logic cfg_err_q;

   always_ff @(posedge clk or negedge reset)
      if (!reset) cfg_err_q <= 1'b0;
      else        cfg_err_q <= cfg_wr && (int'(cfg_ch) >= CH_NUM);

   assign cfg_err = cfg_err_q;

   for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
      localparam logic [DIV_W-1:0] DEF_DIV = (c == 0) ? DEF_DIV0 : DEF_DIV1;
      logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, div_sh_q, div_sh_d;
      logic mode_q, mode_d, mode_sh_q, mode_sh_d, pend_q, pend_d;
      logic clk_q, clk_d, tick_q, tick_d;
      logic wr, tc, half;

      assign wr   = cfg_wr && (int'(cfg_ch) == c);
      assign tc   = cnt_q == div_q;
      assign half = cnt_q == (div_q >> 1);

      always_comb begin
         cnt_d     = cnt_q;
         div_d     = div_q;
         mode_d    = mode_q;
         div_sh_d  = div_sh_q;
         mode_sh_d = mode_sh_q;
         pend_d    = pend_q;
         clk_d     = 1'b0;
         tick_d    = 1'b0;
         if (!en[c]) begin
            cnt_d = '0;
            if (pend_q) begin
               div_d  = div_sh_q;
               mode_d = mode_sh_q;
               pend_d = 1'b0;
            end
         end else if (sync) begin
            cnt_d = '0;
            clk_d = !mode_q;
         end else begin
            cnt_d  = tc ? '0 : cnt_q + 1'b1;
            tick_d = tc;
            // set on TC wins over clear at half period, so div==0 holds high
            clk_d  = mode_q ? tc : (tc || (clk_q && !half));
            if (tc && pend_q) begin
               div_d  = div_sh_q;
               mode_d = mode_sh_q;
               pend_d = 1'b0;
            end
         end
         if (wr) begin
            div_sh_d  = cfg_div;
            mode_sh_d = cfg_mode;
`ifdef SIM_CLOCK_GEN_IMMEDIATE_EN
            div_d  = cfg_div;
            mode_d = cfg_mode;
            pend_d = 1'b0;
            cnt_d  = '0;
            clk_d  = 1'b0;
            tick_d = 1'b0;
`else
            pend_d = 1'b1;
`endif
         end
      end

      always_ff @(posedge clk or negedge reset)
         if (!reset) begin
            cnt_q     <= '0;
            div_q     <= DEF_DIV;
            mode_q    <= DEF_MODE;
            div_sh_q  <= DEF_DIV;
            mode_sh_q <= DEF_MODE;
            pend_q    <= 1'b0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
         end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            mode_q    <= mode_d;
            div_sh_q  <= div_sh_d;
            mode_sh_q <= mode_sh_d;
            pend_q    <= pend_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
         end

      assign clk_out[c] = clk_q;
      assign tick[c]    = tick_q;
   end
endmodule
